// File: rtl/key_scheduler_multimode_sequential.sv
// Sequential AES-128/192/256 key expansion that fills the full round-key vector
// for the GCM-AES round pipeline, N_WORDS_PER_CYCLE key words per enabled clock.
module key_scheduler_multimode_sequential #(
    parameter int NB_BYTE           = 8,
    parameter int N_BYTES_STATE     = 16,
    parameter int N_BYTES_KEY_MAX   = 32,
    parameter int N_ROUNDS_MAX      = 14,
    parameter int N_WORDS_PER_CYCLE = 4
) (
    input  logic                                               i_clock,
    input  logic                                               i_reset,
    input  logic                                               i_valid,
    input  logic                                               i_trigger_schedule,
    input  logic [1:0]                                         i_key_size,
    input  logic [N_BYTES_KEY_MAX*NB_BYTE-1:0]                 i_key,
    output logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS_MAX+1)-1:0]  o_round_key_vector,
    output logic [3:0]                                         o_n_rounds,
    output logic                                               o_busy,
    output logic                                               o_output_ready,
    output logic                                               o_error
);

    localparam int KEY_W   = N_BYTES_KEY_MAX * NB_BYTE;
    localparam int RK_W    = N_BYTES_STATE * NB_BYTE;
    localparam int WPR     = N_BYTES_STATE / 4;
    localparam int N_WORDS = WPR * (N_ROUNDS_MAX + 1);
    localparam int NK_MAX  = N_BYTES_KEY_MAX / 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // AES forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_P = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_P[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [31:0] w_q [N_WORDS];
    logic [31:0] w_d [N_WORDS];
    logic [6:0]  cnt_q, cnt_d, total_q, total_d, total_sel;
    logic [2:0]  pos_q, pos_d;
    logic [3:0]  rcon_idx_q, rcon_idx_d;
    logic [3:0]  nk_q, nk_d, nr_q, nr_d, nk_sel, nr_sel;
    logic        error_q, error_d;
    logic        accept;
    logic [31:0] t;
    logic [5:0]  idx;

    assign accept  = i_valid & i_trigger_schedule & (i_key_size != 2'b11);
    assign error_d = i_valid & i_trigger_schedule & (i_key_size == 2'b11);

    always_comb begin
        nk_sel    = 4'd4;
        nr_sel    = 4'd10;
        total_sel = 7'd44;
        case (i_key_size)
            2'b01: begin nk_sel = 4'd6; nr_sel = 4'd12; total_sel = 7'd52; end
            2'b10: begin nk_sel = 4'd8; nr_sel = 4'd14; total_sel = 7'd60; end
            default: ;
        endcase
    end

    // pos tracks i mod Nk and rcon_idx tracks i / Nk, avoiding a divider.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        w_d        = w_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        rcon_idx_d = rcon_idx_q;
        nk_d       = nk_q;
        nr_d       = nr_q;
        total_d    = total_q;
        t          = '0;
        idx        = '0;
        if (accept) begin
            nk_d       = nk_sel;
            nr_d       = nr_sel;
            total_d    = total_sel;
            cnt_d      = {3'b000, nk_sel};
            pos_d      = '0;
            rcon_idx_d = 4'd1;
            for (int i = 0; i < N_WORDS; i++) w_d[i] = '0;
            for (int i = 0; i < NK_MAX; i++)
                if (i < int'(nk_sel)) w_d[i] = i_key[KEY_W-1-32*i -: 32];
        end else if (state_q == RUN && i_valid) begin
            // NOTE: blocking updates of w_d let each word in the chain see the one just computed.
            for (int j = 0; j < N_WORDS_PER_CYCLE; j++) begin
                if (cnt_d < total_q) begin
                    idx = cnt_d[5:0];
                    t   = w_d[idx - 6'd1];
                    if (pos_d == 3'd0)
                        t = sub_word({t[23:0], t[31:24]}) ^ {rcon(rcon_idx_d), 24'h0};
                    else if (nk_q == 4'd8 && pos_d == 3'd4)
                        t = sub_word(t);
                    w_d[idx] = w_d[idx - {2'b00, nk_q}] ^ t;
                end
                cnt_d = cnt_d + 7'd1;
                if ({1'b0, pos_d} == nk_q - 4'd1) begin
                    pos_d      = '0;
                    rcon_idx_d = rcon_idx_d + 4'd1;
                end else begin
                    pos_d = pos_d + 3'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            RUN:     if (cnt_d >= total_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) state_d = RUN;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // NOTE: the word array is reset too because it drives the output vector directly.
            for (int i = 0; i < N_WORDS; i++) w_q[i] <= '0;
            cnt_q      <= '0;
            total_q    <= '0;
            pos_q      <= '0;
            rcon_idx_q <= '0;
            nk_q       <= '0;
            nr_q       <= '0;
            error_q    <= 1'b0;
        end else begin
            w_q        <= w_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            pos_q      <= pos_d;
            rcon_idx_q <= rcon_idx_d;
            nk_q       <= nk_d;
            nr_q       <= nr_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        o_busy         = (state_q == RUN);
        o_output_ready = (state_q == DONE);
    end

    always_comb begin
        o_round_key_vector = '0;
        for (int r = 0; r <= N_ROUNDS_MAX; r++)
            for (int k = 0; k < WPR; k++)
                o_round_key_vector[r*RK_W + (WPR-1-k)*32 +: 32] = w_q[r*WPR + k];
    end

    assign o_n_rounds = nr_q;
    assign o_error    = error_q;

endmodule

// File: tb/tb_key_scheduler_multimode_sequential.sv
// Scoreboard bench for key_scheduler_multimode_sequential: a 4-word/clock and a
// 1-word/clock instance checked against an independent GF(2^8) key-expansion model.
module tb_key_scheduler_multimode_sequential;

    localparam int VEC_W = 1920;

    typedef struct {
        logic [VEC_W-1:0] vec;
        logic [3:0]       nr;
        int               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, valid, trig, use_slow;
    logic [1:0]       key_size;
    logic [255:0]     key;
    logic             trig_f, trig_s;
    logic [VEC_W-1:0] vec_f, vec_s, vec;
    logic [3:0]       nr_f, nr_s, nr;
    logic             busy_f, busy_s, busy, rdy_f, rdy_s, rdy, err_f, err_s, err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_cnt  = 0;
    int   err_cnt  = 0;
    exp_t sb[$];

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    assign trig_f = trig & ~use_slow;
    assign trig_s = trig & use_slow;
    assign vec    = use_slow ? vec_s  : vec_f;
    assign nr     = use_slow ? nr_s   : nr_f;
    assign busy   = use_slow ? busy_s : busy_f;
    assign rdy    = use_slow ? rdy_s  : rdy_f;
    assign err    = use_slow ? err_s  : err_f;

    key_scheduler_multimode_sequential #(.N_WORDS_PER_CYCLE(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_trigger_schedule(trig_f),
        .i_key_size(key_size), .i_key(key), .o_round_key_vector(vec_f), .o_n_rounds(nr_f),
        .o_busy(busy_f), .o_output_ready(rdy_f), .o_error(err_f)
    );

    key_scheduler_multimode_sequential #(.N_WORDS_PER_CYCLE(1)) dut_slow (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_trigger_schedule(trig_s),
        .i_key_size(key_size), .i_key(key), .o_round_key_vector(vec_s), .o_n_rounds(nr_s),
        .o_busy(busy_s), .o_output_ready(rdy_s), .o_error(err_s)
    );

    // Outputs change after the edge, so sampling at the edge sees the previous cycle.
    always @(posedge clk) begin
        if (rdy) rdy_cnt++;
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw_ref(input logic [31:0] w);
        return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    endfunction

    function automatic logic [VEC_W-1:0] model(input logic [255:0] k, input int nk);
        logic [31:0]      w [60];
        logic [31:0]      t;
        logic [7:0]       rc;
        logic [VEC_W-1:0] v;
        int               total;
        total = 4 * (nk + 7);
        rc    = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw_ref(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        v = '0;
        for (int r = 0; r < 15; r++) v[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return v;
    endfunction

    // One full schedule: push the expectation, trigger, wait for ready, pop and compare.
    task automatic run(input string name, input logic [255:0] k, input logic [1:0] ks,
                       input bit toggle, input int err_at);
        exp_t e;
        int   nk, nwpc, total, c, edges, rdy0, err0;
        bit   inj;
        nk     = (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : 8;
        nwpc   = use_slow ? 1 : 4;
        total  = 4 * (nk + 7);
        c      = (total - nk + nwpc - 1) / nwpc;
        e.lat  = toggle ? 2 * c + 1 : c + 1;
        e.nr   = 4'(nk + 6);
        e.vec  = model(k, nk);
        sb.push_back(e);

        @(negedge clk);
        valid = 1'b1; trig = 1'b1; key = k; key_size = ks;
        @(posedge clk);
        @(negedge clk);
        trig  = 1'b0;
        edges = 1;
        rdy0  = rdy_cnt;
        err0  = err_cnt;
        check({name, " busy"}, 128'(busy), 128'd1);
        if (toggle) valid = 1'b0;
        while (!rdy && edges < 300) begin
            inj = (edges == err_at);
            if (inj) begin trig = 1'b1; key_size = 2'b11; end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (inj) begin
                trig = 1'b0; key_size = ks;
                check({name, " err pulse"}, 128'(err), 128'd1);
            end
            if (toggle) valid = ~valid;
        end
        valid = 1'b1;

        e = sb.pop_front();
        check({name, " latency"}, 128'(edges), 128'(e.lat));
        check({name, " n_rounds"}, 128'(nr), 128'(e.nr));
        check({name, " busy at ready"}, 128'(busy), 128'd0);
        for (int r = 0; r < 15; r++)
            check($sformatf("%s rk%0d", name, r), vec[r*128 +: 128], e.vec[r*128 +: 128]);
        @(negedge clk);
        check({name, " ready width"}, 128'(rdy), 128'd0);
        check({name, " ready count"}, 128'(rdy_cnt - rdy0), 128'd1);
        check({name, " error count"}, 128'(err_cnt - err0), (err_at >= 0) ? 128'd1 : 128'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy0;
        rst = 1'b1; valid = 1'b0; trig = 1'b0; key_size = 2'b00; key = '0; use_slow = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset n_rounds", 128'(nr), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset ready", 128'(rdy), 128'd0);
        check("reset error", 128'(err), 128'd0);
        check("reset rk0", vec[127:0], 128'd0);

        run("aes128", K128, 2'b00, 1'b0, -1);
        check("aes128 kat rk10", vec[10*128 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run("aes192", K192, 2'b01, 1'b0, -1);
        check("aes192 kat w51", 128'(vec[12*128 +: 32]), 128'h01002202);
        run("aes256", K256, 2'b10, 1'b0, -1);
        check("aes256 kat w59", 128'(vec[14*128 +: 32]), 128'h706c631e);
        run("aes128 toggle", K128, 2'b00, 1'b1, -1);

        // Reserved key size while idle: error pulse only, nothing else moves.
        @(negedge clk);
        trig = 1'b1; key_size = 2'b11;
        @(negedge clk);
        trig = 1'b0; key_size = 2'b00;
        check("idle err pulse", 128'(err), 128'd1);
        check("idle err busy", 128'(busy), 128'd0);
        check("idle err n_rounds", 128'(nr), 128'd10);
        @(negedge clk);
        check("idle err width", 128'(err), 128'd0);

        run("aes192 err in run", K192, 2'b01, 1'b0, 5);

        // Start a 128-bit schedule, then retrigger it with the 256-bit key.
        @(negedge clk);
        trig = 1'b1; key = K128; key_size = 2'b00;
        @(negedge clk);
        trig = 1'b0;
        repeat (4) @(negedge clk);
        run("retrig256", K256, 2'b10, 1'b0, -1);

        // Reset in the middle of a schedule aborts it.
        rdy0 = rdy_cnt;
        @(negedge clk);
        trig = 1'b1; key = K192; key_size = 2'b01;
        @(negedge clk);
        trig = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort n_rounds", 128'(nr), 128'd0);
        check("abort busy", 128'(busy), 128'd0);
        check("abort ready", 128'(rdy), 128'd0);
        check("abort error", 128'(err), 128'd0);
        for (int r = 0; r < 15; r++)
            check($sformatf("abort rk%0d", r), vec[r*128 +: 128], 128'd0);
        repeat (70) @(negedge clk);
        check("abort no ready", 128'(rdy_cnt - rdy0), 128'd0);
        check("abort idle busy", 128'(busy), 128'd0);

        use_slow = 1'b1;
        run("aes256 w1", K256, 2'b10, 1'b0, -1);
        check("aes256 w1 kat w59", 128'(vec[14*128 +: 32]), 128'h706c631e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
